time_trigger_wb_slave: RTL and testbench



---
 rtl/time_trigger_pkg.sv | 29 ++
 rtl/time_trigger_cmp.sv | 45 ++++
 rtl/time_trigger_wb_slave.sv | 170 +++++++++++++++++
 tb/tb_time_trigger_wb_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_trigger_pkg.sv
// Shared definitions for the absolute-time trigger responder.
// Holds the Wishbone word-address map, the CTRL bit positions and a
// helper that expands Wishbone byte selects into a 32-bit write mask.
package time_trigger_pkg;

    // Word addresses (byte offset >> 2)
    localparam logic [2:0] c_ADDR_CTRL              = 3'd0;  // 0x00
    localparam logic [2:0] c_ADDR_SECONDS_UPPER     = 3'd2;  // 0x08
    localparam logic [2:0] c_ADDR_SECONDS_LOWER     = 3'd3;  // 0x0C
    localparam logic [2:0] c_ADDR_CYCLES            = 3'd4;  // 0x10
    localparam logic [2:0] c_ADDR_TAG_CYCLES        = 3'd5;  // 0x14
    localparam logic [2:0] c_ADDR_TAG_SECONDS_LOWER = 3'd6;  // 0x18

    // CTRL bit positions
    localparam int c_CTRL_ENABLE = 0;
    localparam int c_CTRL_LATE   = 1;
    localparam int c_CTRL_FIRED  = 2;

    // One select bit per byte lane -> eight mask bits per lane.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/time_trigger_cmp.sv
// Registered comparator of the current White Rabbit time against the armed
// target, both presented as one concatenated {seconds, cycles} word.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   en           - compare allowed this cycle (armed and time valid)
//   cur_time     - current {tai, cycles}
//   target_time  - programmed {seconds, cycles}
//   match        - registered: cur_time == target_time while enabled
//   late         - registered: cur_time >  target_time while enabled
//   cur_time_q   - cur_time delayed one cycle, aligned with match/late
module time_trigger_cmp #(
    parameter int g_width = 68
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [g_width-1:0] cur_time,
    input  logic [g_width-1:0] target_time,
    output logic               match,
    output logic               late,
    output logic [g_width-1:0] cur_time_q
);

    // Once a result is pending the top clears ENABLE on the next edge.
    // Suppressing the compare for that one cycle keeps a fire from being
    // followed by a spurious late as time moves past the target.
    logic active;
    assign active = en & ~match & ~late;

    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match      <= 1'b0;
            late       <= 1'b0;
            cur_time_q <= '0;
        end else begin
            match      <= active && (cur_time == target_time);
            late       <= active && (cur_time >  target_time);
            cur_time_q <= cur_time;
        end
    end

endmodule

// File: rtl/time_trigger_wb_slave.sv
// Wishbone pipelined responder arming a one-shot trigger at an absolute
// White Rabbit time. Fires a single-cycle trig_o when {tai, cycles} equals
// the programmed target, then disarms; arming in the past sets LATE instead.
//
// Ports:
//   sys_clk_i, sys_rst_n_i      - 125 MHz clock, async active-low reset
//   wb_*                        - Wishbone pipelined slave (stall tied 0)
//   wr_tm_time_valid_i          - WR time valid
//   wr_tm_tai_i, wr_tm_cycles_i - current WR time
//   trig_o                      - one-cycle trigger pulse
//   trig_tag_o                  - {tai, cycles} captured at the fire
module time_trigger_wb_slave
    import time_trigger_pkg::*;
#(
    parameter int g_cycles_width  = 28,
    parameter int g_seconds_width = 40
) (
    input  logic                                    sys_clk_i,
    input  logic                                    sys_rst_n_i,
    input  logic                                    wb_cyc_i,
    input  logic                                    wb_stb_i,
    input  logic                                    wb_we_i,
    input  logic [2:0]                              wb_adr_i,
    input  logic [3:0]                              wb_sel_i,
    input  logic [31:0]                             wb_dat_i,
    output logic [31:0]                             wb_dat_o,
    output logic                                    wb_ack_o,
    output logic                                    wb_stall_o,
    input  logic                                    wr_tm_time_valid_i,
    input  logic [g_seconds_width-1:0]              wr_tm_tai_i,
    input  logic [g_cycles_width-1:0]               wr_tm_cycles_i,
    output logic                                    trig_o,
    output logic [g_seconds_width+g_cycles_width-1:0] trig_tag_o
);

    localparam int c_TIME_W   = g_seconds_width + g_cycles_width;
    localparam int c_SEC_HI_W = g_seconds_width - 32;

    logic                       ctrl_enable, ctrl_late, ctrl_fired;
    logic [g_seconds_width-1:0] target_sec, tag_sec;
    logic [g_cycles_width-1:0]  target_cyc, tag_cyc;

    logic        wb_req, wb_wr;
    logic [31:0] wb_mask;
    logic [2:0]  rd_adr;
    logic        rd_valid;
    logic [31:0] rd_data;

    logic                cmp_match, cmp_late;
    logic [c_TIME_W-1:0] cmp_time;
    logic                fire, late_evt;

    assign wb_req     = wb_cyc_i & wb_stb_i;
    assign wb_wr      = wb_req & wb_we_i;
    assign wb_mask    = sel_to_mask(wb_sel_i);
    assign wb_stall_o = 1'b0;

    time_trigger_cmp #(
        .g_width (c_TIME_W)
    ) u_cmp (
        .clk         (sys_clk_i),
        .rst_n       (sys_rst_n_i),
        .en          (ctrl_enable & wr_tm_time_valid_i),
        .cur_time    ({wr_tm_tai_i, wr_tm_cycles_i}),
        .target_time ({target_sec, target_cyc}),
        .match       (cmp_match),
        .late        (cmp_late),
        .cur_time_q  (cmp_time)
    );

    // A result only takes effect if software has not disarmed meanwhile.
    assign fire     = cmp_match & ctrl_enable;
    assign late_evt = cmp_late  & ctrl_enable;

    // Bus handshake: ack one cycle after every accepted strobe.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wb_ack_o <= 1'b0;
            rd_valid <= 1'b0;
            rd_adr   <= '0;
        end else begin
            wb_ack_o <= wb_req;
            rd_valid <= wb_req & ~wb_we_i;
            if (wb_req) begin
                rd_adr <= wb_adr_i;
            end
        end
    end

    // Register bank and trigger state.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            ctrl_enable <= 1'b0;
            ctrl_late   <= 1'b0;
            ctrl_fired  <= 1'b0;
            target_sec  <= '0;
            target_cyc  <= '0;
            tag_sec     <= '0;
            tag_cyc     <= '0;
            trig_o      <= 1'b0;
        end else begin
            trig_o <= fire;

            if (wb_wr) begin
                case (wb_adr_i)
                    c_ADDR_CTRL: begin
                        if (wb_sel_i[0]) begin
                            ctrl_enable <= wb_dat_i[c_CTRL_ENABLE];
                            if (wb_dat_i[c_CTRL_LATE])  ctrl_late  <= 1'b0;
                            if (wb_dat_i[c_CTRL_FIRED]) ctrl_fired <= 1'b0;
                        end
                    end
                    c_ADDR_SECONDS_UPPER: begin
                        target_sec[g_seconds_width-1:32] <=
                            (target_sec[g_seconds_width-1:32] & ~wb_mask[c_SEC_HI_W-1:0]) |
                            (wb_dat_i[c_SEC_HI_W-1:0] & wb_mask[c_SEC_HI_W-1:0]);
                    end
                    c_ADDR_SECONDS_LOWER: begin
                        target_sec[31:0] <= (target_sec[31:0] & ~wb_mask) |
                                            (wb_dat_i & wb_mask);
                    end
                    c_ADDR_CYCLES: begin
                        target_cyc <= (target_cyc & ~wb_mask[g_cycles_width-1:0]) |
                                      (wb_dat_i[g_cycles_width-1:0] & wb_mask[g_cycles_width-1:0]);
                    end
                    default: ;
                endcase
            end

            // NOTE: these hardware updates come after the bus write on
            // purpose; the last non-blocking assignment to a flop wins, so
            // fire/late override a same-cycle ENABLE set or FIRED/LATE clear.
            if (fire) begin
                ctrl_enable <= 1'b0;
                ctrl_fired  <= 1'b1;
                tag_sec     <= cmp_time[c_TIME_W-1:g_cycles_width];
                tag_cyc     <= cmp_time[g_cycles_width-1:0];
            end
            if (late_evt) begin
                ctrl_enable <= 1'b0;
                ctrl_late   <= 1'b1;
            end
        end
    end

    assign trig_tag_o = {tag_sec, tag_cyc};

    // Read data is muxed from the live registers during the ack cycle, so
    // a read accepted on the fire edge already sees FIRED=1, ENABLE=0.
    always_comb begin
        // NOTE: default first so every path assigns rd_data; no latch.
        rd_data = '0;
        case (rd_adr)
            c_ADDR_CTRL: begin
                rd_data[c_CTRL_ENABLE] = ctrl_enable;
                rd_data[c_CTRL_LATE]   = ctrl_late;
                rd_data[c_CTRL_FIRED]  = ctrl_fired;
            end
            c_ADDR_SECONDS_UPPER:     rd_data[c_SEC_HI_W-1:0] = target_sec[g_seconds_width-1:32];
            c_ADDR_SECONDS_LOWER:     rd_data = target_sec[31:0];
            c_ADDR_CYCLES:            rd_data[g_cycles_width-1:0] = target_cyc;
            c_ADDR_TAG_CYCLES:        rd_data[g_cycles_width-1:0] = tag_cyc;
            c_ADDR_TAG_SECONDS_LOWER: rd_data = tag_sec[31:0];
            default: ;
        endcase
    end

    assign wb_dat_o = rd_valid ? rd_data : '0;

endmodule

// File: tb/tb_time_trigger_wb_slave.sv
// Directed bench for time_trigger_wb_slave: register access, fire, late,
// valid gating, same-cycle write/fire collision, pipelined reads, reset.
module tb_time_trigger_wb_slave;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack, stall;
    logic        valid;
    logic [39:0] tai;
    logic [27:0] cycles;
    logic        trig;
    logic [67:0] tag;

    int n_cmp  = 0;
    int n_fail = 0;
    int trig_cnt = 0;
    logic [31:0] d;

    time_trigger_wb_slave #(
        .g_cycles_width  (28),
        .g_seconds_width (40)
    ) dut (
        .sys_clk_i          (clk),
        .sys_rst_n_i        (rst_n),
        .wb_cyc_i           (cyc),
        .wb_stb_i           (stb),
        .wb_we_i            (we),
        .wb_adr_i           (adr),
        .wb_sel_i           (sel),
        .wb_dat_i           (dat_w),
        .wb_dat_o           (dat_r),
        .wb_ack_o           (ack),
        .wb_stall_o         (stall),
        .wr_tm_time_valid_i (valid),
        .wr_tm_tai_i        (tai),
        .wr_tm_cycles_i     (cycles),
        .trig_o             (trig),
        .trig_tag_o         (tag)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Count trigger pulses on the inactive edge.
    always @(negedge clk) begin
        if (trig === 1'b1) trig_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] v, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = v; sel = s;
        step();
        check("ack_wr", ack, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] v);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        step();
        check("ack_rd", ack, 1);
        v = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0;
        dat_w = '0; valid = 1'b0; tai = '0; cycles = '0;
        step(); step(); step();

        // ---- reset state ----
        check("rst_dat", dat_r, 0);
        check("rst_ack", ack, 0);
        check("rst_stall", stall, 0);
        check("rst_trig", trig, 0);
        check("rst_tag", tag, 0);
        rst_n = 1'b1;
        step();
        wb_read(3'd0, d);
        check("ctrl_after_rst", d, 32'h0);
        step();
        check("single_ack", ack, 0);

        // ---- normal fire ----
        valid = 1'b1;
        wb_write(3'd2, 32'h32, 4'hF);
        wb_write(3'd3, 32'h5a34, 4'hF);
        wb_write(3'd4, 32'h1000, 4'hF);
        wb_write(3'd0, 32'h1, 4'hF);
        wb_read(3'd0, d);
        check("ctrl_armed", d, 32'h1);
        tai = 40'h32_0000_5a34; cycles = 28'h1000;
        step();                              // compare edge N
        check("trig_before", trig, 0);
        cycles = 28'h1001;
        wb_read(3'd0, d);                    // accepted at N+1
        check("ctrl_fire_cycle", d, 32'h4);
        check("trig_pulse", trig, 1);
        check("tag_fire1", tag, {40'h32_0000_5a34, 28'h1000});
        step();
        check("trig_one_cycle", trig, 0);
        wb_read(3'd5, d);
        check("tag_cycles", d, 32'h1000);
        wb_read(3'd6, d);
        check("tag_sec_lo", d, 32'h5a34);
        check("trig_cnt1", trig_cnt, 1);

        // ---- late arming ----
        wb_write(3'd0, 32'h4, 4'h1);
        wb_read(3'd0, d);
        check("fired_w1c", d, 32'h0);
        wb_write(3'd2, 32'h0, 4'hF);
        wb_write(3'd3, 32'h32, 4'hF);
        wb_write(3'd4, 32'h1000, 4'hF);
        tai = 40'h32; cycles = 28'h2000;
        wb_write(3'd0, 32'h1, 4'hF);
        step(); step();
        check("late_no_trig", trig, 0);
        wb_read(3'd0, d);
        check("ctrl_late", d, 32'h2);
        wb_write(3'd0, 32'h2, 4'hF);
        wb_read(3'd0, d);
        check("late_w1c", d, 32'h0);
        check("trig_cnt2", trig_cnt, 1);

        // ---- valid low holds ENABLE ----
        valid = 1'b0;
        wb_write(3'd3, 32'h40, 4'hF);
        wb_write(3'd4, 32'h100, 4'hF);
        tai = 40'h40; cycles = 28'h0;
        wb_write(3'd0, 32'h1, 4'hF);
        step();
        cycles = 28'h100;
        step();
        cycles = 28'h200;
        step(); step();
        wb_read(3'd0, d);
        check("ctrl_valid_low", d, 32'h1);
        valid = 1'b1;
        step(); step(); step();
        wb_read(3'd0, d);
        check("ctrl_valid_late", d, 32'h2);
        check("trig_cnt3", trig_cnt, 1);
        wb_write(3'd0, 32'h2, 4'hF);

        // ---- CTRL write in the fire cycle (ENABLE set + FIRED clear) ----
        wb_write(3'd3, 32'h50, 4'hF);
        wb_write(3'd4, 32'h10, 4'hF);
        tai = 40'h50; cycles = 28'h0;
        wb_write(3'd0, 32'h1, 4'hF);
        cycles = 28'h10;
        step();                              // compare edge N
        cycles = 28'h11;
        wb_write(3'd0, 32'h5, 4'h1);         // lands on fire edge N+1
        check("trig_collide", trig, 1);
        check("tag_fire2", tag, {40'h50, 28'h10});
        step();
        wb_read(3'd0, d);
        check("ctrl_collide", d, 32'h4);
        check("trig_cnt4", trig_cnt, 2);

        // ---- byte selects, unmapped offsets, pipelined reads ----
        wb_write(3'd2, 32'hFFFF_FFA5, 4'hF);
        wb_write(3'd3, 32'hDEAD_BEEF, 4'hF);
        wb_write(3'd3, 32'h1122_3344, 4'h5);
        wb_write(3'd4, 32'hFFFF_FFFF, 4'hF);
        wb_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        wb_read(3'd1, d);
        check("unmapped_1", d, 32'h0);
        wb_read(3'd7, d);
        check("unmapped_7", d, 32'h0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
        adr = 3'd0; step();
        check("burst_ack0", ack, 1);
        check("burst_ctrl", dat_r, 32'h4);
        adr = 3'd2; step();
        check("burst_ack1", ack, 1);
        check("burst_sec_hi", dat_r, 32'hA5);
        adr = 3'd3; step();
        check("burst_ack2", ack, 1);
        check("burst_sec_lo", dat_r, 32'hDE22_BE44);
        adr = 3'd4; step();
        check("burst_ack3", ack, 1);
        check("burst_cycles", dat_r, 32'h0FFF_FFFF);
        cyc = 1'b0; stb = 1'b0;
        step();
        check("burst_ack_end", ack, 0);

        // ---- reset while armed ----
        wb_write(3'd2, 32'h0, 4'hF);
        wb_write(3'd3, 32'h60, 4'hF);
        wb_write(3'd4, 32'h20, 4'hF);
        tai = 40'h60; cycles = 28'h0;
        wb_write(3'd0, 32'h5, 4'hF);
        wb_read(3'd0, d);
        check("ctrl_rearm", d, 32'h1);
        cycles = 28'h20;
        step();                              // match pending in comparator
        rst_n = 1'b0;
        #1;
        check("rst_mid_trig", trig, 0);
        check("rst_mid_tag", tag, 0);
        check("rst_mid_dat", dat_r, 0);
        step(); step();
        rst_n = 1'b1;
        step(); step(); step(); step(); step();
        check("trig_cnt_rst", trig_cnt, 2);
        wb_read(3'd0, d);
        check("ctrl_after_rst2", d, 32'h0);
        wb_read(3'd4, d);
        check("cycles_after_rst", d, 32'h0);
        wb_read(3'd5, d);
        check("tag_after_rst", d, 32'h0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
